// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the IFU, LSU and downstream memory port
// signals of mem_port_arbiter. The "master" modport is the arbiter's view
// (it masters the memory port and answers the core); "slave" is the
// surrounding environment (core requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_reqValid;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_respValid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_reqValid;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_wmask;
  logic [1:0]        lsu_size;
  logic              lsu_respValid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_reqValid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic [1:0]        mem_size;
  logic              mem_respValid;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_timeout;

  modport master (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
    output err_timeout
  );

  modport slave (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_size,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_size,
    input  err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU with one
// outstanding request at a time and alternating grants under contention.
// Optional build macro ARB_TIMEOUT_EN adds a WAIT-state watchdog that forces
// a 32'hdeadbeef response and pulses err_timeout after TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic       GRANT_IFU = 1'b0;
  localparam logic       GRANT_LSU = 1'b1;
  localparam logic [1:0] IFU_SIZE  = 2'b10;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hdeadbeef);
  logic [15:0] wait_cnt_q, wait_cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic              ifu_resp_q, ifu_resp_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic              lsu_resp_q, lsu_resp_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              err_q, err_d;
  logic              pick_lsu;

  // LSU wins when it is alone, or when both wait and IFU was served last.
  assign pick_lsu = bus.lsu_reqValid & (~bus.ifu_reqValid | (last_q == GRANT_IFU));

  // Next-state, request latching and response capture for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_size_d  = mem_size_q;
    ifu_resp_d  = 1'b0;
    ifu_rdata_d = ifu_rdata_q;
    lsu_resp_d  = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.ifu_reqValid || bus.lsu_reqValid) begin
          grant_d   = pick_lsu;
          last_d    = pick_lsu;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
          if (pick_lsu) begin
            mem_addr_d  = bus.lsu_addr;
            mem_wen_d   = bus.lsu_wen;
            mem_wdata_d = bus.lsu_wdata;
            mem_wmask_d = bus.lsu_wmask;
            mem_size_d  = bus.lsu_size;
          end else begin
            mem_addr_d  = bus.ifu_addr;
            mem_wen_d   = 1'b0;
            mem_wdata_d = {DATA_W{1'b0}};
            mem_wmask_d = 4'b0000;
            mem_size_d  = IFU_SIZE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = 16'd0;
`endif
      end
      S_WAIT: begin
        if (bus.mem_respValid) begin
          state_d = S_RESP;
          if (grant_q == GRANT_LSU) begin
            lsu_rdata_d = bus.mem_rdata;
            lsu_resp_d  = 1'b1;
          end else begin
            ifu_rdata_d = bus.mem_rdata;
            ifu_resp_d  = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (grant_q == GRANT_LSU) begin
            lsu_rdata_d = TIMEOUT_DATA;
            lsu_resp_d  = 1'b1;
          end else begin
            ifu_rdata_d = TIMEOUT_DATA;
            ifu_resp_d  = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        // Requests seen during the response cycle are deliberately ignored.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= GRANT_IFU;
      last_q      <= GRANT_IFU;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_wmask_q <= 4'b0000;
      mem_size_q  <= 2'b00;
      ifu_resp_q  <= 1'b0;
      ifu_rdata_q <= {DATA_W{1'b0}};
      lsu_resp_q  <= 1'b0;
      lsu_rdata_q <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_size_q  <= mem_size_d;
      ifu_resp_q  <= ifu_resp_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_resp_q  <= lsu_resp_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.mem_reqValid  = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.ifu_respValid = ifu_resp_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_respValid = lsu_resp_q;
  assign bus.lsu_rdata     = lsu_rdata_q;
  assign bus.err_timeout   = err_q;

endmodule
